// File: rtl/rf_write_scheduler.sv
// Purpose : serialises ALU and mul/div writebacks onto the single register-file write port.
// Latency : ext handshake -> Rd write next cycle, R0 write the cycle after; wb via FIFO -> write 2 cycles after handshake.
// Backpressure: wb_ready drops when the FIFO is full; ext_ready drops mid-pair or when a FIFO entry is owed a turn.
//
// Ports:
//   clk, reset (async, active-low)
//   wb_valid/wb_ready/wb_reg/wb_data          normal writeback requester (buffered in a DEPTH-entry FIFO)
//   ext_valid/ext_ready/ext_reg/ext_lo/ext_hi extended writeback (lo -> ext_reg, hi -> R0)
//   write_reg/write_data/r0/reg_write         registered register-file write controls
//   read_reg1/read_reg2/busy/hazard           decode-side pending-write mask and stall request
// Optional macro RF_SCHED_STATS_EN adds stall_cycles[15:0] and ext_conflicts[7:0] saturating counters.

module rf_write_scheduler #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [3:0]  ext_reg,
    input  logic [15:0] ext_lo,
    input  logic [15:0] ext_hi,
    output logic [3:0]  write_reg,
    output logic [15:0] write_data,
    output logic [15:0] r0,
    output logic [1:0]  reg_write,
    input  logic [3:0]  read_reg1,
    input  logic [3:0]  read_reg2,
    output logic [15:0] busy,
    output logic        hazard
`ifdef RF_SCHED_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [7:0]  ext_conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_A  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    localparam logic           GRANT_A   = 1'b0;
    localparam logic           GRANT_EXT = 1'b1;
    localparam logic [2:0]     DEPTH_W   = 3'(DEPTH);

    localparam logic [1:0]     RW_IDLE   = 2'b00;
    localparam logic [1:0]     RW_RD     = 2'b11;
    localparam logic [1:0]     RW_R0     = 2'b01;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  count_q, count_d;
    // Slot 0 is always the FIFO head; popping shifts the remaining entries down.
    logic [3:0]  fifo_reg_q  [DEPTH];
    logic [3:0]  fifo_reg_d  [DEPTH];
    logic [15:0] fifo_data_q [DEPTH];
    logic [15:0] fifo_data_d [DEPTH];
    logic [3:0]  write_reg_q, write_reg_d;
    logic [15:0] write_data_q, write_data_d;
    logic [15:0] r0_q, r0_d;
    logic [1:0]  reg_write_q, reg_write_d;
    logic [15:0] ext_hi_q, ext_hi_d;

    logic        push;
    logic        pop;
    logic        ext_fire;
    logic        fifo_empty;
    logic [2:0]  wr_idx;
    logic [15:0] busy_c;

    assign fifo_empty = (count_q == 3'd0);
    // Full blocks a push even when the head pops this same cycle.
    assign wb_ready   = (count_q < DEPTH_W);
    // Ext may only win when no FIFO entry is owed its round-robin turn.
    assign ext_ready  = (state_q != WR_LO) && (fifo_empty || (last_grant_q == GRANT_A));
    assign push       = wb_valid && wb_ready;
    assign ext_fire   = ext_valid && ext_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        r0_d         = r0_q;
        reg_write_d  = reg_write_q;
        ext_hi_d     = ext_hi_q;
        fifo_reg_d   = fifo_reg_q;
        fifo_data_d  = fifo_data_q;
        pop          = 1'b0;

        case (state_q)
            WR_LO: begin
                // The second half of an ext pair is never preempted.
                state_d     = WR_HI;
                reg_write_d = RW_R0;
                r0_d        = ext_hi_q;
            end
            default: begin
                if (ext_fire) begin
                    state_d      = WR_LO;
                    last_grant_d = GRANT_EXT;
                    reg_write_d  = RW_RD;
                    write_reg_d  = ext_reg;
                    write_data_d = ext_lo;
                    ext_hi_d     = ext_hi;
                end else if (!fifo_empty) begin
                    pop          = 1'b1;
                    state_d      = WR_A;
                    last_grant_d = GRANT_A;
                    reg_write_d  = RW_RD;
                    write_reg_d  = fifo_reg_q[0];
                    write_data_d = fifo_data_q[0];
                end else begin
                    state_d     = IDLE;
                    reg_write_d = RW_IDLE;
                end
            end
        endcase

        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_reg_d[i]  = fifo_reg_q[i+1];
                fifo_data_d[i] = fifo_data_q[i+1];
            end
        end

        // A new entry lands just behind the surviving entries.
        wr_idx = count_q - {2'b00, pop};
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == 3'(i)) begin
                    fifo_reg_d[i]  = wb_reg;
                    fifo_data_d[i] = wb_data;
                end
            end
        end

        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Pending-write mask. During WR_LO/WR_HI write_reg_q still holds the
    // captured ext destination, so it stands in for the captured ext_reg.
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) < count_q) begin
                busy_c[fifo_reg_q[i]] = 1'b1;
            end
        end
        case (state_q)
            WR_A: begin
                busy_c[write_reg_q] = 1'b1;
            end
            WR_LO, WR_HI: begin
                busy_c[write_reg_q] = 1'b1;
                busy_c[0]           = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy       = busy_c;
    // The register file cannot serve reads while its port is writing.
    assign hazard     = busy_c[read_reg1] | busy_c[read_reg2] | (reg_write_q != RW_IDLE);
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign r0         = r0_q;
    assign reg_write  = reg_write_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_A;
            count_q      <= 3'd0;
            write_reg_q  <= 4'd0;
            write_data_q <= 16'd0;
            r0_q         <= 16'd0;
            reg_write_q  <= RW_IDLE;
            ext_hi_q     <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= 4'd0;
                fifo_data_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            r0_q         <= r0_d;
            reg_write_q  <= reg_write_d;
            ext_hi_q     <= ext_hi_d;
            fifo_reg_q   <= fifo_reg_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

`ifdef RF_SCHED_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [7:0]  ext_conflicts_q, ext_conflicts_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        ext_conflicts_d = ext_conflicts_q;
        if (hazard && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (ext_valid && !ext_ready && (ext_conflicts_q != 8'hFF)) begin
            ext_conflicts_d = ext_conflicts_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q  <= 16'd0;
            ext_conflicts_q <= 8'd0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            ext_conflicts_q <= ext_conflicts_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign ext_conflicts = ext_conflicts_q;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;

    localparam int DEPTH = 2;

    typedef struct { logic [3:0] rg; logic [15:0] dat; int arrive; } wb_exp_t;
    typedef struct { logic [3:0] rg; logic [15:0] lo; logic [15:0] hi; int lo_cyc; } ext_exp_t;
    typedef struct { logic [3:0] rg; logic [15:0] dat; int gap; } wb_stim_t;
    typedef struct { logic [3:0] rg; logic [15:0] lo; logic [15:0] hi; int gap; } ext_stim_t;

    logic        clk;
    logic        reset;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        ext_valid, ext_ready;
    logic [3:0]  ext_reg;
    logic [15:0] ext_lo, ext_hi;
    logic [3:0]  write_reg;
    logic [15:0] write_data, r0;
    logic [1:0]  reg_write;
    logic [3:0]  read_reg1, read_reg2;
    logic [15:0] busy;
    logic        hazard;
`ifdef RF_SCHED_STATS_EN
    logic [15:0] stall_cycles;
    logic [7:0]  ext_conflicts;
`endif

    rf_write_scheduler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .ext_reg    (ext_reg),
        .ext_lo     (ext_lo),
        .ext_hi     (ext_hi),
        .write_reg  (write_reg),
        .write_data (write_data),
        .r0         (r0),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .busy       (busy),
        .hazard     (hazard)
`ifdef RF_SCHED_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .ext_conflicts (ext_conflicts)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit rr_zero = 1'b0;

    wb_exp_t   exp_wb_q[$];
    ext_exp_t  exp_ext_q[$];
    wb_stim_t  wb_stim_q[$];
    ext_stim_t ext_stim_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    // Transaction view: an accepted ext owns the port for the two cycles
    // after its handshake; otherwise any wb entry that was already buffered
    // in the previous cycle gets the port, oldest first.
    logic [1:0]  m_rw;
    logic [3:0]  m_reg, m_hi_reg;
    logic [15:0] m_dat, m_r0, m_hi_val, m_cur, m_busy;
    logic        m_hi_pend = 1'b0, m_hi_next, m_lo_now, m_last_ext = 1'b0;
    int          m_cnt, m_prev_cnt = 0;
    wb_exp_t     m_w;
    ext_exp_t    m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                m_rw = 2'b00; m_reg = 4'd0; m_dat = 16'd0; m_r0 = 16'd0;
                m_cur = '0; m_lo_now = 1'b0; m_hi_next = 1'b0;
                if (m_hi_pend) begin
                    m_rw = 2'b01; m_r0 = m_hi_val;
                    m_cur[m_hi_reg] = 1'b1; m_cur[0] = 1'b1;
                end else if (exp_ext_q.size() > 0 && exp_ext_q[0].lo_cyc == cyc) begin
                    m_e = exp_ext_q.pop_front();
                    m_rw = 2'b11; m_reg = m_e.rg; m_dat = m_e.lo;
                    m_cur[m_e.rg] = 1'b1; m_cur[0] = 1'b1;
                    m_lo_now = 1'b1; m_last_ext = 1'b1;
                    m_hi_next = 1'b1; m_hi_val = m_e.hi; m_hi_reg = m_e.rg;
                end else if (m_prev_cnt > 0) begin
                    m_w = exp_wb_q.pop_front();
                    m_rw = 2'b11; m_reg = m_w.rg; m_dat = m_w.dat;
                    m_cur[m_w.rg] = 1'b1; m_last_ext = 1'b0;
                end
                m_hi_pend = m_hi_next;

                chk("reg_write", 32'(reg_write), 32'(m_rw));
                if (m_rw == 2'b11) begin
                    chk("write_reg", 32'(write_reg), 32'(m_reg));
                    chk("write_data", 32'(write_data), 32'(m_dat));
                end
                if (m_rw == 2'b01) chk("r0", 32'(r0), 32'(m_r0));

                m_cnt = 0; m_busy = m_cur;
                foreach (exp_wb_q[i]) begin
                    if (exp_wb_q[i].arrive <= cyc) begin
                        m_cnt++;
                        m_busy[exp_wb_q[i].rg] = 1'b1;
                    end
                end
                chk("wb_ready", 32'(wb_ready), 32'(m_cnt < DEPTH));
                chk("ext_ready", 32'(ext_ready), 32'(!m_lo_now && (m_cnt == 0 || !m_last_ext)));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("hazard", 32'(hazard),
                    32'(m_busy[read_reg1] | m_busy[read_reg2] | (m_rw != 2'b00)));
                m_prev_cnt = m_cnt;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_phase(input int budget);
        int n = 0;
        bit wb_hs, ext_hs;
        while ((wb_stim_q.size() > 0 || ext_stim_q.size() > 0 || wb_valid || ext_valid) && n < budget) begin
            @(negedge clk);
            wb_hs  = wb_valid && wb_ready;
            ext_hs = ext_valid && ext_ready;
            if (wb_hs)  exp_wb_q.push_back(wb_exp_t'{wb_reg, wb_data, cyc + 1});
            if (ext_hs) exp_ext_q.push_back(ext_exp_t'{ext_reg, ext_lo, ext_hi, cyc + 1});
            @(posedge clk); #1;
            if (wb_hs)  wb_valid = 1'b0;
            if (ext_hs) ext_valid = 1'b0;
            if (!wb_valid && wb_stim_q.size() > 0) begin
                if (wb_stim_q[0].gap > 0) wb_stim_q[0].gap = wb_stim_q[0].gap - 1;
                else begin
                    wb_stim_t s = wb_stim_q.pop_front();
                    wb_valid = 1'b1; wb_reg = s.rg; wb_data = s.dat;
                end
            end
            if (!ext_valid && ext_stim_q.size() > 0) begin
                if (ext_stim_q[0].gap > 0) ext_stim_q[0].gap = ext_stim_q[0].gap - 1;
                else begin
                    ext_stim_t e = ext_stim_q.pop_front();
                    ext_valid = 1'b1; ext_reg = e.rg; ext_lo = e.lo; ext_hi = e.hi;
                end
            end
            read_reg1 = rr_zero ? 4'd0 : 4'($urandom_range(0, 15));
            read_reg2 = 4'($urandom_range(0, 15));
            n++;
        end
        chk("phase_done", 32'(n < budget), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wb_q.size() > 0 || exp_ext_q.size() > 0 || m_hi_pend) && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drained", 32'(exp_wb_q.size() + exp_ext_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0; wb_reg = 4'd0; wb_data = 16'd0;
        ext_valid = 1'b0; ext_reg = 4'd0; ext_lo = 16'd0; ext_hi = 16'd0;
        read_reg1 = 4'd1; read_reg2 = 4'd2;
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", 32'(write_data), 32'd0);
        chk("rst_r0", 32'(r0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd1);
        chk("rst_ext_ready", 32'(ext_ready), 32'd1);
        reset = 1'b1;
        mon_en = 1'b1;

        // single normal writeback
        wb_stim_q.push_back(wb_stim_t'{4'd5, 16'h1234, 1});
        run_phase(200); drain();

        // single ext pair
        ext_stim_q.push_back(ext_stim_t'{4'd3, 16'hBEEF, 16'h0001, 0});
        run_phase(200); drain();

        // ext targeting R0, decode reading R0 throughout
        rr_zero = 1'b1;
        ext_stim_q.push_back(ext_stim_t'{4'd0, 16'h00AA, 16'h5555, 0});
        run_phase(200); drain();
        rr_zero = 1'b0;

        // FIFO fills while an ext pair holds the port
        ext_stim_q.push_back(ext_stim_t'{4'd2, 16'h0F0F, 16'hF0F0, 0});
        wb_stim_q.push_back(wb_stim_t'{4'd4, 16'h1111, 0});
        wb_stim_q.push_back(wb_stim_t'{4'd7, 16'h2222, 0});
        wb_stim_q.push_back(wb_stim_t'{4'd9, 16'h3333, 0});
        run_phase(200); drain();

        // ext held with two FIFO entries after an ext grant: A, LO, HI, A
        ext_stim_q.push_back(ext_stim_t'{4'd5, 16'h1111, 16'h2222, 0});
        ext_stim_q.push_back(ext_stim_t'{4'd9, 16'h3333, 16'h4444, 0});
        wb_stim_q.push_back(wb_stim_t'{4'd6, 16'hAAAA, 0});
        wb_stim_q.push_back(wb_stim_t'{4'd8, 16'hBBBB, 0});
        run_phase(200); drain();

        // randomized mix
        for (int i = 0; i < 60; i++)
            wb_stim_q.push_back(wb_stim_t'{4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 3))});
        for (int i = 0; i < 30; i++)
            ext_stim_q.push_back(ext_stim_t'{4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 5))});
        run_phase(3000); drain();

        // reset asserted in the middle of an ext pair
        @(posedge clk); #1;
        mon_en = 1'b0;
        ext_valid = 1'b1; ext_reg = 4'd7; ext_lo = 16'hCAFE; ext_hi = 16'h1357;
        @(posedge clk); #1;
        ext_valid = 1'b0;
        chk("mid_lo_reg_write", 32'(reg_write), 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hazard", 32'(hazard), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_hi", 32'(reg_write), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        chk("post_rst_ext_ready", 32'(ext_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
